vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16/96/48: horizontal front porch, sync and back porch widths, in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10/2/33: vertical front porch, sync and back porch heights, in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0: sync active level (0 = active-low).
REQ-006 SHALL have parameter CLK_DIV, default 2, legal range 1..8: clk cycles per pixel.
REQ-007 SHALL have parameter PIPE, default 2, legal range 0..4: delay, in pixel strobes, applied to sync/blank outputs.
REQ-008 SHALL have parameter CW, default 10: width of the x and y counters.
REQ-009 SHALL have port clk, input, 1 bit: single system clock, all logic on the rising edge.
REQ-010 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port en, input, 1 bit: timing runs when 1, freezes when 0.
REQ-012 SHALL have port pix_en, output, 1 bit: one-clk strobe per pixel.
REQ-013 SHALL have ports x and y, outputs, CW bits each: current pixel column and line, undelayed.
REQ-014 SHALL have ports hsync and vsync, outputs, 1 bit each: sync signals, delayed PIPE strobes.
REQ-015 SHALL have port blank_b, output, 1 bit: 1 inside the visible area, delayed PIPE strobes.
REQ-016 SHALL have port sync_b, output, 1 bit: tied to constant 0.
REQ-017 SHALL have port line_start, output, 1 bit: one-clk pulse when x becomes 0.
REQ-018 SHALL have port frame_start, output, 1 bit: one-clk pulse when x and y both become 0.
REQ-019 SHALL have port frame_cnt, output, 8 bits: completed-frame counter.

Function
REQ-020 SHALL assert pix_en for one clk every CLK_DIV clks, driven by a divider counter 0..CLK_DIV-1; with CLK_DIV=1, pix_en SHALL stay high continuously.
REQ-021 SHALL advance x only on pix_en with en=1; x wraps from H_TOTAL-1 (H_ACTIVE+H_FP+H_SYNC+H_BP) to 0.
REQ-022 SHALL increment y only on an x wrap; y wraps from V_TOTAL-1 to 0, and frame_cnt increments (mod 256) on that same edge.
REQ-023 SHALL run a horizontal FSM with states ACT, HFP, HSY, HBP: ACT->HFP at x=H_ACTIVE, HFP->HSY at x=H_ACTIVE+H_FP, HSY->HBP at x=H_ACTIVE+H_FP+H_SYNC, HBP->ACT at the x wrap.
REQ-024 SHALL run a vertical FSM with the same four states over y, stepping only on x wraps.
REQ-025 SHALL drive the undelayed sync as HS_POL in HSY and ~HS_POL otherwise; vsync likewise with VS_POL.
REQ-026 SHALL drive the undelayed blank_b as 1 only when both FSMs are in ACT.
REQ-027 SHALL pass undelayed hsync/vsync/blank_b through a PIPE-stage shift register that advances only on pix_en; with PIPE=0 they SHALL be combinational from the FSMs.
REQ-028 SHALL assert line_start and frame_start on the clk edge where the counter update occurs, each lasting exactly one clk.
REQ-029 SHALL, when en=0, hold the divider, counters, FSMs and pipeline, hold pix_en and pulses at 0, and keep the held sync/blank levels.
REQ-030 SHALL keep x < 2^CW and y < 2^CW; a configuration whose H_TOTAL or V_TOTAL exceeds 2^CW is illegal and SHALL be rejected at elaboration.

Reset
REQ-031 SHALL, while rst=0, asynchronously force: divider, x, y, frame_cnt to 0; both FSMs to ACT; pix_en, line_start, frame_start, blank_b to 0; hsync to ~HS_POL; vsync to ~VS_POL; all pipeline stages to inactive (blank 0, syncs inactive).
REQ-032 SHALL, on rst asserted mid-frame, abort immediately with no partial pulse; after release, the first pix_en occurs CLK_DIV clks later and counting restarts at x=0, y=0 without a frame_start for that first pixel.

Verification
REQ-033 Defaults, full frame: run 800x525x2 clks -> hsync low for exactly 96 pixels per line, vsync low for exactly 2 lines, frame_cnt=1, frame_start pulsed once.
REQ-034 Wrap: at x=799, y=524 with pix_en -> next clk x=0, y=0, line_start=1, frame_start=1, frame_cnt increments by 1.
REQ-035 Pipeline: PIPE=2, CLK_DIV=1 -> blank_b falls 2 clks after x reaches 640; with PIPE=0 it falls in the same cycle.
REQ-036 Freeze: en=0 for 37 clks at x=100 -> x stays 100, pix_en stays 0; after en=1, continues at 101.
REQ-037 Reset mid-frame: rst=0 at x=300, y=200 -> all outputs at reset values within the same clk with no edge; after release, x=0, y=0.
REQ-038 Polarity/divider: HS_POL=1, VS_POL=1, CLK_DIV=4 -> pix_en period 4 clks; hsync high for 96x4 clks per line.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: run enable into the generator, pixel strobe,
// counters, sync/blank levels and line/frame markers out of it.
interface vga_timing_gen_if #(
  parameter int CW = 10
) ();
  logic          en;
  logic          pix_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          hsync;
  logic          vsync;
  logic          blank_b;
  logic          sync_b;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frame_cnt;

  modport master (
    input  en,
    output pix_en, x, y, hsync, vsync, blank_b, sync_b,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  pix_en, x, y, hsync, vsync, blank_b, sync_b,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-clock divider, x/y counters, horizontal and
// vertical phase FSMs, and a pixel-strobed delay line for sync/blank.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int PIPE     = 2,
  parameter int CW       = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_timing_gen_if.master     vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Each phase boundary is detected on a single counter value, so no phase may be empty.
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CW");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8 || PIPE < 0 || PIPE > 4) begin : g_bad_range
    $error("vga_timing_gen: CLK_DIV must be 1..8 and PIPE 0..4");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase
    $error("vga_timing_gen: every timing phase must be at least 1 long");
  end

  typedef enum logic [1:0] {ACT, HFP, HSY, HBP} state_e;

  logic [2:0]    div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  state_e        h_st_q, h_st_d, v_st_q, v_st_d;
  logic          hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
  logic          blank_raw_q, blank_raw_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic adv, div_last, x_last, y_last;

  // pix_en_q is held (not cleared) while frozen so no pixel strobe is lost.
  assign adv      = vga.en & pix_en_q;
  assign div_last = (div_q == 3'(CLK_DIV - 1));
  assign x_last   = (x_q == CW'(H_TOTAL - 1));
  assign y_last   = (y_q == CW'(V_TOTAL - 1));

  always_comb begin
    div_d         = div_q;
    pix_en_d      = pix_en_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_cnt_d   = frame_cnt_q;
    h_st_d        = h_st_q;
    v_st_d        = v_st_q;
    hs_raw_d      = hs_raw_q;
    vs_raw_d      = vs_raw_q;
    blank_raw_d   = blank_raw_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (vga.en) begin
      div_d    = div_last ? 3'd0 : div_q + 3'd1;
      pix_en_d = div_last;
    end

    if (adv) begin
      x_d          = x_last ? '0 : x_q + 1'b1;
      line_start_d = x_last;
      case (h_st_q)
        ACT:     if (x_d == CW'(H_ACTIVE)) h_st_d = HFP;
        HFP:     if (x_d == CW'(H_ACTIVE + H_FP)) h_st_d = HSY;
        HSY:     if (x_d == CW'(H_ACTIVE + H_FP + H_SYNC)) h_st_d = HBP;
        HBP:     if (x_last) h_st_d = ACT;
        default: h_st_d = ACT;
      endcase

      if (x_last) begin
        y_d           = y_last ? '0 : y_q + 1'b1;
        frame_start_d = y_last;
        if (y_last) frame_cnt_d = frame_cnt_q + 8'd1;
        case (v_st_q)
          ACT:     if (y_d == CW'(V_ACTIVE)) v_st_d = HFP;
          HFP:     if (y_d == CW'(V_ACTIVE + V_FP)) v_st_d = HSY;
          HSY:     if (y_d == CW'(V_ACTIVE + V_FP + V_SYNC)) v_st_d = HBP;
          HBP:     if (y_last) v_st_d = ACT;
          default: v_st_d = ACT;
        endcase
      end

      // Levels follow the next state so they line up with the new x/y.
      hs_raw_d    = (h_st_d == HSY) ? HS_POL : ~HS_POL;
      vs_raw_d    = (v_st_d == HSY) ? VS_POL : ~VS_POL;
      blank_raw_d = (h_st_d == ACT) && (v_st_d == ACT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= 3'd0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_cnt_q   <= 8'd0;
      h_st_q        <= ACT;
      v_st_q        <= ACT;
      hs_raw_q      <= ~HS_POL;
      vs_raw_q      <= ~VS_POL;
      blank_raw_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_cnt_q   <= frame_cnt_d;
      h_st_q        <= h_st_d;
      v_st_q        <= v_st_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      blank_raw_q   <= blank_raw_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  localparam logic [2:0] IDLE_LVL = {~HS_POL, ~VS_POL, 1'b0};

  logic [2:0] raw_lvl;
  logic [2:0] out_lvl;

  assign raw_lvl = {hs_raw_q, vs_raw_q, blank_raw_q};

  if (PIPE == 0) begin : g_nopipe
    assign out_lvl = raw_lvl;
  end else begin : g_pipe
    for (genvar gi = 0; gi < PIPE; gi++) begin : stg
      logic [2:0] lvl_q, lvl_d, src;
      if (gi == 0) begin : g_head
        assign src = raw_lvl;
      end else begin : g_tail
        assign src = stg[gi-1].lvl_q;
      end
      always_comb begin
        lvl_d = lvl_q;
        if (adv) lvl_d = src;
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) lvl_q <= IDLE_LVL;
        else      lvl_q <= lvl_d;
      end
    end
    assign out_lvl = stg[PIPE-1].lvl_q;
  end

  assign vga.pix_en      = pix_en_q & vga.en;
  assign vga.line_start  = line_start_q & vga.en;
  assign vga.frame_start = frame_start_q & vga.en;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_cnt   = frame_cnt_q;
  assign vga.hsync       = out_lvl[2];
  assign vga.vsync       = out_lvl[1];
  assign vga.blank_b     = out_lvl[0];
  assign vga.sync_b      = 1'b0;

endmodule
